// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and constant masks shared by the sequential ALU core.
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_ROL  = 4'h4;
  localparam logic [3:0] OP_ROR  = 4'h5;
  localparam logic [3:0] OP_PENC = 4'h6;
  localparam logic [3:0] OP_GRAY = 4'h7;
  localparam logic [3:0] OP_MAJ  = 4'h8;
  localparam logic [3:0] OP_MOD  = 4'h9;
  localparam logic [3:0] OP_AND  = 4'hA;
  localparam logic [3:0] OP_OR   = 4'hB;
  localparam logic [3:0] OP_NOT  = 4'hC;
  localparam logic [3:0] OP_XOR  = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  // repeated 2'b10 pattern, truncated by the user to its operand width
  function automatic logic [63:0] alt_mask();
    return {32{2'b10}};
  endfunction
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock, WIDTH iterations.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST = CW'(1);
  logic [WIDTH-1:0] dsr, rem_src, quo_src, rem_nxt, quo_nxt;
  logic [WIDTH:0] shifted, diff;
  logic [CW-1:0] cnt;
  // the start cycle already performs the first iteration on the raw operands
  always_comb begin
    rem_src = start ? '0 : remainder;
    quo_src = start ? dividend : quotient;
    shifted = {rem_src, quo_src[WIDTH-1]};
    diff = shifted - {1'b0, start ? divisor : dsr};
    rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nxt = {quo_src[WIDTH-2:0], ~diff[WIDTH]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dsr <= '0;
      quotient <= '0;
      remainder <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      dsr <= divisor;
      quotient <= quo_nxt;
      remainder <= rem_nxt;
      cnt <= INIT;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      quotient <= quo_nxt;
      remainder <= rem_nxt;
      cnt <= cnt - 1'b1;
      busy <= cnt != LAST;
      done <= cnt == LAST;
    end else begin
      done <= 1'b0;
    end
endmodule

// File: rtl/seq_alu_core.sv
// seq_alu_core: handshaked WIDTH-bit 16-op ALU with accumulator chaining and a multi-cycle divide.
module seq_alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MOD_Q    = 17,
  parameter int SECRET_S = 3,
  parameter int ERROR_E  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_sign,
  output logic             out_error
);
  localparam int MW = 2 * WIDTH + 2;
  localparam logic [WIDTH-1:0] ALT = WIDTH'(alt_mask());
  state_t state, state_nxt;
  logic [WIDTH-1:0] acc, a, res, penc, div_q, unused_rem;
  logic [WIDTH:0] sum, dif;
  logic [2*WIDTH-1:0] prod;
  logic accept, div_zero, div_start, div_done, carry, unused_busy;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_ready && in_valid;
  assign a = in_acc ? acc : in_a;
  assign div_zero = in_op == OP_DIV && in_b == '0;
  assign div_start = accept && in_op == OP_DIV && !div_zero;
  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start(div_start),
    .dividend(a),
    .divisor(in_b),
    .busy(unused_busy),
    .done(div_done),
    .quotient(div_q),
    .remainder(unused_rem)
  );
  // every non-divide op, plus divide by zero, resolves here in the accept cycle
  always_comb begin
    sum = {1'b0, a} + {1'b0, in_b};
    dif = {1'b0, a} - {1'b0, in_b};
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, in_b};
    penc = '1;
    for (int i = 0; i < WIDTH; i++) if (a[i]) penc = WIDTH'(i);
    res = '0;
    carry = 1'b0;
    case (in_op)
      OP_ADD:  {carry, res} = sum;
      OP_SUB:  {carry, res} = dif;
      OP_MUL:  begin
        res = prod[WIDTH-1:0];
        carry = |prod[2*WIDTH-1:WIDTH];
      end
      OP_ROL:  res = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  res = {a[0], a[WIDTH-1:1]};
      OP_PENC: res = penc;
      OP_GRAY: res = a ^ (a >> 1);
      OP_MAJ:  res = (a & in_b) | (a & ALT) | (in_b & ~ALT);
      OP_MOD:  res = WIDTH'((MW'(a) * MW'(SECRET_S) + MW'(ERROR_E)) % MW'(MOD_Q));
      OP_AND:  res = a & in_b;
      OP_OR:   res = a | in_b;
      OP_NOT:  res = ~a;
      OP_XOR:  res = a ^ in_b;
      OP_GT:   res = {{(WIDTH-1){1'b0}}, a > in_b};
      OP_EQ:   res = {{(WIDTH-1){1'b0}}, a == in_b};
      default: res = '0;
    endcase
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = div_start ? DIV : DONE;
      DIV:     if (div_done) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_result <= '0;
      out_zero <= 1'b0;
      out_carry <= 1'b0;
      out_sign <= 1'b0;
      out_error <= 1'b0;
      acc <= '0;
    end else begin
      if (accept && !div_start) begin
        out_result <= res;
        out_zero <= res == '0 || div_zero;
        out_carry <= carry;
        out_sign <= (in_op <= OP_DIV) && res[WIDTH-1];
        out_error <= div_zero;
      end else if (state == DIV && div_done) begin
        out_result <= div_q;
        out_zero <= div_q == '0;
        out_carry <= 1'b0;
        out_sign <= div_q[WIDTH-1];
        out_error <= 1'b0;
      end
      if (out_valid && out_ready) acc <= out_result;
    end
endmodule

// File: tb/tb_seq_alu_core.sv
// tb_seq_alu_core: directed self-checking bench for seq_alu_core at WIDTH=8.
module tb_seq_alu_core;
  import alu_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_acc = 1'b0, out_ready = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic [3:0] in_op = '0;
  logic in_ready, out_valid, out_zero, out_carry, out_sign, out_error;
  logic [7:0] out_result;
  int checks = 0, errors = 0;

  seq_alu_core #(.WIDTH(8), .MOD_Q(17), .SECRET_S(3), .ERROR_E(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_carry(out_carry), .out_sign(out_sign), .out_error(out_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a, b, res;
    logic z, c, s;
  } vec_t;

  localparam vec_t TV [14] = '{
    '{OP_MOD,  8'd10,  8'h00, 8'd15,  1'b0, 1'b0, 1'b0},
    '{OP_PENC, 8'h00,  8'h00, 8'hFF,  1'b0, 1'b0, 1'b0},
    '{OP_PENC, 8'h24,  8'h00, 8'h05,  1'b0, 1'b0, 1'b0},
    '{OP_GRAY, 8'h5A,  8'h00, 8'h77,  1'b0, 1'b0, 1'b0},
    '{OP_MAJ,  8'hF0,  8'h3C, 8'hB4,  1'b0, 1'b0, 1'b0},
    '{OP_ROL,  8'h81,  8'h00, 8'h03,  1'b0, 1'b0, 1'b0},
    '{OP_ROR,  8'h81,  8'h00, 8'hC0,  1'b0, 1'b0, 1'b0},
    '{OP_MUL,  8'd20,  8'd20, 8'h90,  1'b0, 1'b1, 1'b1},
    '{OP_GT,   8'd9,   8'd3,  8'h01,  1'b0, 1'b0, 1'b0},
    '{OP_EQ,   8'd5,   8'd6,  8'h00,  1'b1, 1'b0, 1'b0},
    '{OP_AND,  8'hF0,  8'h3C, 8'h30,  1'b0, 1'b0, 1'b0},
    '{OP_OR,   8'hF0,  8'h3C, 8'hFC,  1'b0, 1'b0, 1'b0},
    '{OP_XOR,  8'h3C,  8'h3C, 8'h00,  1'b1, 1'b0, 1'b0},
    '{OP_SUB,  8'd9,   8'd9,  8'h00,  1'b1, 1'b0, 1'b0}
  };

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic acc);
    in_a = a; in_b = b; in_op = op; in_acc = acc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_acc = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if ({out_result, out_zero, out_carry, out_sign, out_error} !== 12'h000) begin
      errors++; $display("FAIL reset_outputs: got %h expected 000", {out_result, out_zero, out_carry, out_sign, out_error});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    issue(8'd200, 8'd100, OP_ADD, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", out_valid); end
    checks++; if (out_result !== 8'd44) begin errors++; $display("FAIL add_result: got %0d expected 44", out_result); end
    checks++; if ({out_carry, out_zero, out_sign, out_error} !== 4'b1000) begin
      errors++; $display("FAIL add_flags czse: got %b expected 1000", {out_carry, out_zero, out_sign, out_error});
    end
    consume();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL add_release: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
    issue(8'd5, 8'd7, OP_SUB, 1'b0);
    checks++; if (out_result !== 8'hFE) begin errors++; $display("FAIL sub_result: got %h expected fe", out_result); end
    checks++; if ({out_carry, out_zero, out_sign, out_error} !== 4'b1010) begin
      errors++; $display("FAIL sub_flags czse: got %b expected 1010", {out_carry, out_zero, out_sign, out_error});
    end
    consume();
  endtask

  task automatic test_divide();
    int n = 1;
    issue(8'd200, 8'd7, OP_DIV, 1'b0);
    while (!out_valid && n < 20) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL div_busy_ready: edge %0d got %b expected 0", n, in_ready); end
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != 9) begin errors++; $display("FAIL div_latency: got %0d edges expected 9", n); end
    checks++; if (out_result !== 8'd28) begin errors++; $display("FAIL div_result: got %0d expected 28", out_result); end
    checks++; if ({out_carry, out_zero, out_sign, out_error} !== 4'b0000) begin
      errors++; $display("FAIL div_flags czse: got %b expected 0000", {out_carry, out_zero, out_sign, out_error});
    end
    consume();
    issue(8'd200, 8'd0, OP_DIV, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL divz_valid: got %b expected 1", out_valid); end
    checks++; if (out_result !== 8'd0) begin errors++; $display("FAIL divz_result: got %h expected 00", out_result); end
    checks++; if ({out_carry, out_zero, out_sign, out_error} !== 4'b0101) begin
      errors++; $display("FAIL divz_flags czse: got %b expected 0101", {out_carry, out_zero, out_sign, out_error});
    end
    consume();
  endtask

  task automatic test_ops();
    for (int i = 0; i < 14; i++) begin
      issue(TV[i].a, TV[i].b, TV[i].op, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL op%0d_valid: got %b expected 1", i, out_valid); end
      checks++; if (out_result !== TV[i].res) begin errors++; $display("FAIL op%0d_result: got %h expected %h", i, out_result, TV[i].res); end
      checks++; if ({out_zero, out_carry, out_sign, out_error} !== {TV[i].z, TV[i].c, TV[i].s, 1'b0}) begin
        errors++; $display("FAIL op%0d_flags zcse: got %b expected %b", i, {out_zero, out_carry, out_sign, out_error}, {TV[i].z, TV[i].c, TV[i].s, 1'b0});
      end
      consume();
    end
  endtask

  task automatic test_chain();
    issue(8'd5, 8'd3, OP_ADD, 1'b0);
    checks++; if (out_result !== 8'd8) begin errors++; $display("FAIL chain_first: got %0d expected 8", out_result); end
    consume();
    issue(8'hAA, 8'd10, OP_ADD, 1'b1);
    checks++; if (out_result !== 8'd18) begin errors++; $display("FAIL chain_acc_add: got %0d expected 18", out_result); end
    consume();
    issue(8'h11, 8'd0, OP_NOT, 1'b1);
    checks++; if (out_result !== 8'hED) begin errors++; $display("FAIL chain_acc_not: got %h expected ed", out_result); end
    consume();
  endtask

  task automatic test_backpressure();
    issue(8'd3, 8'd4, OP_MUL, 1'b0);
    in_a = 8'd1; in_b = 8'd1; in_op = OP_ADD; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold%0d_handshake: got valid=%b ready=%b expected 1 0", i, out_valid, in_ready);
      end
      checks++; if ({out_result, out_zero, out_carry, out_sign, out_error} !== {8'd12, 4'b0000}) begin
        errors++; $display("FAIL hold%0d_stable: got %h expected 0c0", i, {out_result, out_zero, out_carry, out_sign, out_error});
      end
    end
    in_valid = 1'b0;
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_ignored: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_divide();
    issue(8'd200, 8'd7, OP_DIV, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_handshake: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
    checks++; if (out_result !== 8'd0) begin errors++; $display("FAIL abort_result: got %h expected 00", out_result); end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL abort_no_result%0d: got valid=%b ready=%b expected 0 1", i, out_valid, in_ready);
      end
    end
    issue(8'h33, 8'd5, OP_ADD, 1'b1);
    checks++; if (out_result !== 8'd5) begin errors++; $display("FAIL abort_acc_cleared: got %0d expected 5", out_result); end
    consume();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_divide();
    test_ops();
    test_chain();
    test_backpressure();
    test_reset_mid_divide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
